// File: rtl/dcl_1778_8_if.sv
// Signal bundle for the duty-cycle meter: measured input, reference clock,
// measurement results and the multiplexed 7-segment display drive.
interface dcl_1778_8_if;
    logic       ft;
    logic       fout;
    logic [9:0] tH;
    logic [9:0] T;
    logic [3:0] q4;
    logic [3:0] q3;
    logic [3:0] q2;
    logic [3:0] q1;
    logic [7:0] SEG;
    logic [6:0] codeout;
    logic       dot;

    modport master (
        output ft,
        input  fout, tH, T, q4, q3, q2, q1, SEG, codeout, dot
    );

    modport slave (
        input  ft,
        output fout, tH, T, q4, q3, q2, q1, SEG, codeout, dot
    );
endinterface

// File: rtl/dcl_1778_8.sv
// Duty-cycle meter: counts 1 MHz ticks over the high time and the period of
// ft, divides to 0.1 % units, converts to BCD and scans a 4-digit display.
module dcl_1778_8 (
    input  logic        clk,
    input  logic        clr,
    dcl_1778_8_if.slave bus
);
    localparam int unsigned DIV_N  = 50;
    localparam int unsigned DIV_W  = 6;
    localparam int unsigned CNT_W  = 10;
    localparam int unsigned NUM_W  = 20;
    localparam int unsigned STEP_W = 5;
    localparam int unsigned SCAN_W = 10;
    localparam int unsigned BCD_W  = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [DIV_W-1:0]    div_cnt;
    logic [DIV_W-1:0]    div_nxt;
    logic                tick;
    logic                fs1;
    logic                fs;
    logic                fs_d;
    logic                rise;
    logic [CNT_W-1:0]    pc;
    logic [CNT_W-1:0]    hc;
    logic                valid;
    logic                upd;
    logic [NUM_W-1:0]    num;
    logic [CNT_W-1:0]    den;
    logic [CNT_W-1:0]    rem;
    logic [STEP_W-1:0]   step;
    logic [CNT_W:0]      rem_sh;
    logic [CNT_W:0]      rem_sub;
    logic                ge;
    logic [SCAN_W-1:0]   scan_cnt;
    logic [1:0]          pos;
    logic [3:0]          digit;

    function automatic logic [BCD_W-1:0] to_bcd(input logic [CNT_W-1:0] bin);
        logic [BCD_W-1:0] acc;
        acc = '0;
        for (int i = CNT_W - 1; i >= 0; i--) begin
            for (int d = 0; d < 4; d++) begin
                if (acc[4*d +: 4] > 4'd4) acc[4*d +: 4] = acc[4*d +: 4] + 4'd3;
            end
            acc = {acc[BCD_W-2:0], bin[i]};
        end
        return acc;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] c;
        case (v)
            4'd0:    c = 7'b1000000;
            4'd1:    c = 7'b1111001;
            4'd2:    c = 7'b0100100;
            4'd3:    c = 7'b0110000;
            4'd4:    c = 7'b0011001;
            4'd5:    c = 7'b0010010;
            4'd6:    c = 7'b0000010;
            4'd7:    c = 7'b1111000;
            4'd8:    c = 7'b0000000;
            4'd9:    c = 7'b0010000;
            default: c = 7'b1111111;
        endcase
        return c;
    endfunction

    assign tick    = (div_cnt == DIV_W'(DIV_N - 1));
    assign div_nxt = tick ? '0 : div_cnt + DIV_W'(1);
    assign rise    = fs & ~fs_d;
    assign rem_sh  = {rem, num[NUM_W-1]};
    assign ge      = (rem_sh >= {1'b0, den});
    assign rem_sub = rem_sh - {1'b0, den};

    // 50:1 reference divider; fout mirrors (count < 25) of the registered count
    always_ff @(posedge clk) begin
        if (clr) begin
            div_cnt  <= '0;
            bus.fout <= 1'b0;
        end else begin
            div_cnt  <= div_nxt;
            bus.fout <= (div_nxt < DIV_W'(DIV_N / 2));
        end
    end

    // Two-flop synchronizer plus one delay stage for edge detection
    always_ff @(posedge clk) begin
        if (clr) begin
            fs1  <= 1'b0;
            fs   <= 1'b0;
            fs_d <= 1'b0;
        end else begin
            fs1  <= bus.ft;
            fs   <= fs1;
            fs_d <= fs;
        end
    end

    // Saturating tick counters; a rising edge publishes and restarts (clear beats tick)
    always_ff @(posedge clk) begin
        if (clr) begin
            pc     <= '0;
            hc     <= '0;
            valid  <= 1'b0;
            upd    <= 1'b0;
            bus.T  <= '0;
            bus.tH <= '0;
        end else begin
            upd <= 1'b0;
            if (rise) begin
                pc    <= '0;
                hc    <= '0;
                valid <= 1'b1;
                if (valid) begin
                    bus.T  <= pc;
                    bus.tH <= hc;
                    upd    <= 1'b1;
                end
            end else if (tick) begin
                if (pc != CNT_MAX) pc <= pc + CNT_W'(1);
                if (fs && (hc != CNT_MAX)) hc <= hc + CNT_W'(1);
            end
        end
    end

    // Divider control state register
    always_ff @(posedge clk) begin
        if (clr) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Divider control: a fresh result always restarts the division
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (upd) state_nxt = S_DIV;
            S_DIV:   if (!upd && (step == STEP_W'(NUM_W - 1))) state_nxt = S_DONE;
            S_DONE:  state_nxt = upd ? S_DIV : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Restoring division of tH*1000 by T, one quotient bit per cycle, then BCD
    always_ff @(posedge clk) begin
        if (clr) begin
            num    <= '0;
            den    <= '0;
            rem    <= '0;
            step   <= '0;
            bus.q4 <= '0;
            bus.q3 <= '0;
            bus.q2 <= '0;
            bus.q1 <= '0;
        end else if (upd) begin
            num  <= NUM_W'(bus.tH) * NUM_W'(1000);
            den  <= bus.T;
            rem  <= '0;
            step <= '0;
        end else if (state == S_DIV) begin
            num  <= {num[NUM_W-2:0], ge};
            rem  <= ge ? rem_sub[CNT_W-1:0] : rem_sh[CNT_W-1:0];
            step <= step + STEP_W'(1);
        end else if (state == S_DONE) begin
            {bus.q4, bus.q3, bus.q2, bus.q1} <= (den == '0) ? '0 : to_bcd(num[CNT_W-1:0]);
        end
    end

    // Digit of the currently scanned position
    always_comb begin
        digit = bus.q1;
        case (pos)
            2'd0: digit = bus.q1;
            2'd1: digit = bus.q2;
            2'd2: digit = bus.q3;
            2'd3: digit = bus.q4;
            default: digit = bus.q1;
        endcase
    end

    // Display scan: one position per 1024 cycles, decimal point left of q1
    always_ff @(posedge clk) begin
        if (clr) begin
            scan_cnt    <= '0;
            pos         <= '0;
            bus.SEG     <= 8'b1111_1110;
            bus.codeout <= 7'b1000000;
            bus.dot     <= 1'b1;
        end else begin
            scan_cnt    <= scan_cnt + SCAN_W'(1);
            if (scan_cnt == '1) pos <= pos + 2'd1;
            bus.SEG     <= {4'hF, ~(4'b0001 << pos)};
            bus.codeout <= seg7(digit);
            bus.dot     <= (pos != 2'd1);
        end
    end
endmodule

// File: tb/tb_dcl_1778_8.sv
// Bench for the duty-cycle meter: table of waveforms with known results,
// hand-written reset/scan/saturation sequences and random ft against a model.
module tb_dcl_1778_8;
    logic clk;
    logic clr;
    int   n_tests;
    int   n_fail;

    dcl_1778_8_if bus();

    dcl_1778_8 dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        int high;
        int low;
        int t;
        int th;
        int q4;
        int q3;
        int q2;
        int q1;
    } vec_t;

    vec_t vecs[5];

    // Reference model: ticks once per 50 clocks, ft seen two clocks late,
    // a rising edge publishes the running counts and restarts them.
    int m_div;
    int m_pc;
    int m_hc;
    int m_T;
    int m_tH;
    bit m_valid;
    bit ft_hist[$];

    always @(posedge clk) begin
        bit fs_now;
        bit fs_old;
        if (clr) begin
            m_div = 0; m_pc = 0; m_hc = 0; m_T = 0; m_tH = 0; m_valid = 0;
            ft_hist.delete();
        end else begin
            fs_now = (ft_hist.size() >= 2) ? ft_hist[ft_hist.size()-2] : 1'b0;
            fs_old = (ft_hist.size() >= 3) ? ft_hist[ft_hist.size()-3] : 1'b0;
            if (fs_now && !fs_old) begin
                if (m_valid) begin
                    m_T  = m_pc;
                    m_tH = m_hc;
                end
                m_pc = 0; m_hc = 0; m_valid = 1;
            end else if (m_div == 49) begin
                if (m_pc < 1023) m_pc++;
                if (fs_now && m_hc < 1023) m_hc++;
            end
            m_div = (m_div + 1) % 50;
            ft_hist.push_back(bus.ft);
            if (ft_hist.size() > 3) void'(ft_hist.pop_front());
        end
    end

    function automatic int exp_duty(input int th, input int t);
        return (t == 0) ? 0 : (th * 1000) / t;
    endfunction

    function automatic int exp_code(input int v);
        case (v)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_fout"}, int'(bus.fout), 0);
        check({tag, "_T"}, int'(bus.T), 0);
        check({tag, "_tH"}, int'(bus.tH), 0);
        check({tag, "_q"}, int'({bus.q4, bus.q3, bus.q2, bus.q1}), 0);
        check({tag, "_SEG"}, int'(bus.SEG), 8'hFE);
        check({tag, "_codeout"}, int'(bus.codeout), 7'b1000000);
        check({tag, "_dot"}, int'(bus.dot), 1);
    endtask

    task automatic check_model(input string tag);
        int d;
        d = exp_duty(m_tH, m_T);
        check({tag, "_T"}, int'(bus.T), m_T);
        check({tag, "_tH"}, int'(bus.tH), m_tH);
        check({tag, "_q4"}, int'(bus.q4), d / 1000);
        check({tag, "_q3"}, int'(bus.q3), (d / 100) % 10);
        check({tag, "_q2"}, int'(bus.q2), (d / 10) % 10);
        check({tag, "_q1"}, int'(bus.q1), d % 10);
    endtask

    task automatic hold(input logic v, input int n);
        bus.ft = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        clr = 1'b1;
        repeat (2) @(negedge clk);
        check_reset("rst");
        clr = 1'b0;
    endtask

    // Arm with one rising edge, then measure on the second one
    task automatic run_vec(input vec_t v, input bit rst, input string tag);
        if (rst) do_reset();
        hold(1'b0, 10);
        hold(1'b1, v.high);
        hold(1'b0, v.low);
        check({tag, "_arm_T"}, int'(bus.T), 0);
        check({tag, "_arm_tH"}, int'(bus.tH), 0);
        hold(1'b1, v.high);
        hold(1'b0, 40);
        check({tag, "_T"}, int'(bus.T), v.t);
        check({tag, "_tH"}, int'(bus.tH), v.th);
        check({tag, "_q"}, int'({bus.q4, bus.q3, bus.q2, bus.q1}),
              int'({4'(v.q4), 4'(v.q3), 4'(v.q2), 4'(v.q1)}));
        check_model({tag, "_model"});
    endtask

    task automatic run_len(input logic v, output int n);
        n = 0;
        while (bus.fout === v && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_seg(input logic [7:0] s, output bit found);
        int k;
        k = 0;
        while (bus.SEG !== s && k < 5000) begin
            @(negedge clk);
            k++;
        end
        found = (bus.SEG === s);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  found;
        int  dur;

        vecs[0] = '{500, 2000, 50, 10, 0, 2, 0, 0};
        vecs[1] = '{1250, 1250, 50, 25, 0, 5, 0, 0};
        vecs[2] = '{100, 400, 10, 2, 0, 2, 0, 0};
        vecs[3] = '{150, 1000, 23, 3, 0, 1, 3, 0};
        vecs[4] = '{350, 150, 10, 7, 0, 7, 0, 0};

        n_tests = 0;
        n_fail  = 0;
        clr     = 1'b1;
        bus.ft  = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("por");
        clr = 1'b0;

        // Reference square wave shape after reset
        run_len(1'b0, n);
        run_len(1'b1, n);
        run_len(1'b0, n);
        check("fout_low", n, 25);
        run_len(1'b1, n);
        check("fout_high", n, 25);
        check("idle_T", int'(bus.T), 0);
        check("idle_tH", int'(bus.tH), 0);
        check("idle_q", int'({bus.q4, bus.q3, bus.q2, bus.q1}), 0);

        foreach (vecs[i]) run_vec(vecs[i], 1'b1, $sformatf("vec%0d", i));

        // 20 % result on the display, then ft idle: values must hold
        run_vec(vecs[0], 1'b1, "scan");
        wait_seg(8'hFD, found);
        check("seg_q2_seen", int'(found), 1);
        check("seg_q2_code", int'(bus.codeout), exp_code(0));
        check("seg_q2_dot", int'(bus.dot), 0);
        n = 0;
        while (bus.SEG === 8'hFD && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("seg_dwell", n, 1024);
        check("seg_q3_sel", int'(bus.SEG), 8'hFB);
        check("seg_q3_code", int'(bus.codeout), exp_code(2));
        check("seg_q3_dot", int'(bus.dot), 1);
        wait_seg(8'hF7, found);
        check("seg_q4_code", int'(bus.codeout), exp_code(0));
        wait_seg(8'hFE, found);
        check("seg_q1_code", int'(bus.codeout), exp_code(0));
        check("hold_T", int'(bus.T), 50);
        check("hold_tH", int'(bus.tH), 10);
        check("hold_q", int'({bus.q4, bus.q3, bus.q2, bus.q1}), 16'h0200);

        // Reset in the middle of a period discards everything
        hold(1'b1, 500);
        hold(1'b0, 1000);
        check_model("pre_clr");
        clr = 1'b1;
        @(negedge clk);
        check_reset("mid_clr");
        clr = 1'b0;
        run_vec(vecs[0], 1'b0, "post_clr");

        // Random ft against the model
        for (int b = 0; b < 3; b++) begin
            for (int s = 0; s < 10; s++) begin
                dur = int'($urandom_range(1, 300));
                hold(~bus.ft, dur);
            end
            hold(1'b0, 60);
            check_model($sformatf("rnd%0d", b));
        end

        // Constant-high input saturates both counters
        do_reset();
        hold(1'b0, 10);
        hold(1'b1, 51300);
        hold(1'b0, 100);
        hold(1'b1, 10);
        hold(1'b0, 40);
        check("sat_T", int'(bus.T), 1023);
        check("sat_tH", int'(bus.tH), 1023);
        check("sat_q", int'({bus.q4, bus.q3, bus.q2, bus.q1}), 16'h1000);
        check_model("sat_model");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
